// File: rtl/jtkunio_rom_pkg.sv
// Shared types and helpers for the Kunio ROM bank arbiter.
package jtkunio_rom_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      WAIT_RDY = 2'd2
   } state_t;

   // Requester indices; the round-robin order follows these values
   localparam logic [1:0] MAIN = 2'd0;
   localparam logic [1:0] SND  = 2'd1;
   localparam logic [1:0] PCM  = 2'd2;
   localparam int         NREQ = 3;

   // First requester in req, searching cyclically from ptr (ptr itself first)
   function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
      logic [1:0] pick;
      int         idx;
      pick = ptr;
      // Walk the order backwards so the closest requester to ptr wins
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) pick = 2'(idx);
      end
      return pick;
   endfunction

   // Requester that gets first look after gnt has been served
   function automatic logic [1:0] rr_next(input logic [1:0] gnt);
      return (gnt == PCM) ? MAIN : gnt + 2'd1;
   endfunction

endpackage

// File: rtl/jtkunio_rom_slot.sv
// One-word read cache for a single 8-bit ROM requester.
// Holds the last fetched 16-bit word and its word address; byte reads that
// fall inside that word are answered combinationally.
module jtkunio_rom_slot #(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_cs,
   input  logic [AW-1:0] i_addr,
   input  logic          i_fill,
   input  logic [AW-2:0] i_fill_tag,
   input  logic [15:0]   i_fill_word,
   output logic [7:0]    o_data,
   output logic          o_ok,
   output logic          o_miss
);

   logic [AW-2:0] r_tag;
   logic [15:0]   r_word;
   logic          r_valid;
   logic          w_hit;

   // Cache storage: cleared during ROM download, written when the arbiter fills this slot
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: word and tag are reset too, so data reads 8'h00 straight out of reset
      // instead of X; the storage is one word, so the reset costs nothing.
      if (!rst_n) begin
         r_tag   <= '0;
         r_word  <= '0;
         r_valid <= 1'b0;
      end else if (i_clr) begin
         // NOTE: non-blocking assignments on every clocked register, so each
         // flop samples values from before the edge regardless of statement order.
         r_valid <= 1'b0;
      end else if (i_fill) begin
         r_tag   <= i_fill_tag;
         r_word  <= i_fill_word;
         r_valid <= 1'b1;
      end
   end

   assign w_hit  = i_cs & r_valid & (i_addr[AW-1:1] == r_tag);
   assign o_ok   = w_hit;
   assign o_miss = i_cs & ~w_hit;
   assign o_data = i_addr[0] ? r_word[15:8] : r_word[7:0];

endmodule

// File: rtl/jtkunio_rom_arb.sv
// Read-only SDRAM bank arbiter for the main CPU, sound CPU and PCM ROMs.
// Each requester has a one-word cache; misses are serialised through a
// single bank port with round-robin grant and one outstanding transaction.
module jtkunio_rom_arb
   import jtkunio_rom_pkg::*;
#(
   parameter int          MAIN_AW    = 16,
   parameter int          SND_AW     = 15,
   parameter int          PCM_AW     = 17,
   parameter logic [21:0] SND_OFFSET = 22'h08000,
   parameter logic [21:0] PCM_OFFSET = 22'h0C000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               downloading,
   input  logic               main_cs,
   input  logic               snd_cs,
   input  logic               pcm_cs,
   input  logic [MAIN_AW-1:0] main_addr,
   input  logic [SND_AW-1:0]  snd_addr,
   input  logic [PCM_AW-1:0]  pcm_addr,
   output logic [7:0]         main_data,
   output logic [7:0]         snd_data,
   output logic [7:0]         pcm_data,
   output logic               main_ok,
   output logic               snd_ok,
   output logic               pcm_ok,
   output logic [21:0]        ba_addr,
   output logic               ba_rd,
   input  logic               ba_ack,
   input  logic               ba_rdy,
   input  logic [15:0]        data_read
);

   // Widest per-requester word address; shared latch for the fill tag
   localparam int MAX_AW = (MAIN_AW > SND_AW) ?
                           ((MAIN_AW > PCM_AW) ? MAIN_AW : PCM_AW) :
                           ((SND_AW  > PCM_AW) ? SND_AW  : PCM_AW);
   localparam int TW = MAX_AW - 1;

   state_t        r_state;
   logic [1:0]    r_gnt;
   logic [1:0]    r_ptr;
   logic [TW-1:0] r_tag;
   logic [21:0]   r_ba_addr;
   logic          r_ba_rd;

   logic [2:0]    w_miss;
   logic [1:0]    w_sel;
   logic [21:0]   w_sel_addr;
   logic [TW-1:0] w_sel_tag;
   logic          w_fill;

   jtkunio_rom_slot #(.AW(MAIN_AW)) u_main (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (downloading),
      .i_cs        (main_cs),
      .i_addr      (main_addr),
      .i_fill      (w_fill && r_gnt == MAIN),
      .i_fill_tag  (r_tag[MAIN_AW-2:0]),
      .i_fill_word (data_read),
      .o_data      (main_data),
      .o_ok        (main_ok),
      .o_miss      (w_miss[MAIN])
   );

   jtkunio_rom_slot #(.AW(SND_AW)) u_snd (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (downloading),
      .i_cs        (snd_cs),
      .i_addr      (snd_addr),
      .i_fill      (w_fill && r_gnt == SND),
      .i_fill_tag  (r_tag[SND_AW-2:0]),
      .i_fill_word (data_read),
      .o_data      (snd_data),
      .o_ok        (snd_ok),
      .o_miss      (w_miss[SND])
   );

   jtkunio_rom_slot #(.AW(PCM_AW)) u_pcm (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (downloading),
      .i_cs        (pcm_cs),
      .i_addr      (pcm_addr),
      .i_fill      (w_fill && r_gnt == PCM),
      .i_fill_tag  (r_tag[PCM_AW-2:0]),
      .i_fill_word (data_read),
      .o_data      (pcm_data),
      .o_ok        (pcm_ok),
      .o_miss      (w_miss[PCM])
   );

   assign w_sel = rr_pick(w_miss, r_ptr);

   // Bank word address and cache tag of the requester the round-robin would pick
   always_comb begin
      // NOTE: defaults first so every path assigns every output; otherwise
      // synthesis infers latches for the unassigned cases.
      w_sel_addr = 22'(main_addr[MAIN_AW-1:1]);
      w_sel_tag  = TW'(main_addr[MAIN_AW-1:1]);
      case (w_sel)
         SND: begin
            w_sel_addr = SND_OFFSET + 22'(snd_addr[SND_AW-1:1]);
            w_sel_tag  = TW'(snd_addr[SND_AW-1:1]);
         end
         PCM: begin
            w_sel_addr = PCM_OFFSET + 22'(pcm_addr[PCM_AW-1:1]);
            w_sel_tag  = TW'(pcm_addr[PCM_AW-1:1]);
         end
         default: ;
      endcase
   end

   // A fill lands on ba_rdy in WAIT_RDY, or together with ba_ack in WAIT_ACK
   assign w_fill = ~downloading &
                   (((r_state == WAIT_ACK) & ba_ack & ba_rdy) |
                    ((r_state == WAIT_RDY) & ba_rdy));

   // Grant FSM: one outstanding bank read, abandoned when a download starts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_gnt     <= MAIN;
         r_ptr     <= MAIN;
         r_tag     <= '0;
         r_ba_addr <= '0;
         r_ba_rd   <= 1'b0;
      end else if (downloading) begin
         r_state <= IDLE;
         r_ba_rd <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_miss) begin
                  r_gnt     <= w_sel;
                  r_tag     <= w_sel_tag;
                  r_ba_addr <= w_sel_addr;
                  r_ba_rd   <= 1'b1;
                  r_state   <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (ba_ack) begin
                  r_ba_rd <= 1'b0;
                  if (ba_rdy) begin
                     r_ptr   <= rr_next(r_gnt);
                     r_state <= IDLE;
                  end else begin
                     r_state <= WAIT_RDY;
                  end
               end
            end
            WAIT_RDY: begin
               if (ba_rdy) begin
                  r_ptr   <= rr_next(r_gnt);
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ba_addr = r_ba_addr;
   assign ba_rd   = r_ba_rd;

endmodule

// File: tb/tb_jtkunio_rom_arb.sv
// Self-checking bench for jtkunio_rom_arb: directed scenarios plus a
// randomized run against a cache/round-robin reference model.
module tb_jtkunio_rom_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        downloading;
   logic        main_cs, snd_cs, pcm_cs;
   logic [15:0] main_addr;
   logic [14:0] snd_addr;
   logic [16:0] pcm_addr;
   logic [7:0]  main_data, snd_data, pcm_data;
   logic        main_ok, snd_ok, pcm_ok;
   logic [21:0] ba_addr;
   logic        ba_rd;
   logic        ba_ack, ba_rdy;
   logic [15:0] data_read;

   int checks   = 0;
   int failures = 0;

   // Reference model: per-requester cached word, word address and valid bit,
   // plus the requester that has first claim on the next grant.
   bit          m_valid [3];
   logic [21:0] m_tag   [3];
   logic [15:0] m_word  [3];
   int          m_ptr;

   jtkunio_rom_arb dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .downloading (downloading),
      .main_cs     (main_cs),
      .snd_cs      (snd_cs),
      .pcm_cs      (pcm_cs),
      .main_addr   (main_addr),
      .snd_addr    (snd_addr),
      .pcm_addr    (pcm_addr),
      .main_data   (main_data),
      .snd_data    (snd_data),
      .pcm_data    (pcm_data),
      .main_ok     (main_ok),
      .snd_ok      (snd_ok),
      .pcm_ok      (pcm_ok),
      .ba_addr     (ba_addr),
      .ba_rd       (ba_rd),
      .ba_ack      (ba_ack),
      .ba_rdy      (ba_rdy),
      .data_read   (data_read)
   );

   always #5 clk = ~clk;

   // Global time bound so a stuck run still ends
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [21:0] offset_of(int i);
      return (i == 0) ? 22'h0 : (i == 1) ? 22'h08000 : 22'h0C000;
   endfunction

   function automatic logic [21:0] req_word(int i);
      case (i)
         0:       return 22'(main_addr >> 1);
         1:       return 22'(snd_addr >> 1);
         default: return 22'(pcm_addr >> 1);
      endcase
   endfunction

   function automatic logic req_cs(int i);
      return (i == 0) ? main_cs : (i == 1) ? snd_cs : pcm_cs;
   endfunction

   function automatic logic req_lsb(int i);
      return (i == 0) ? main_addr[0] : (i == 1) ? snd_addr[0] : pcm_addr[0];
   endfunction

   function automatic logic [21:0] exp_ba(int i);
      return offset_of(i) + req_word(i);
   endfunction

   function automatic logic exp_ok(int i);
      return req_cs(i) && m_valid[i] && (m_tag[i] == req_word(i));
   endfunction

   function automatic logic [7:0] exp_data(int i);
      return req_lsb(i) ? m_word[i][15:8] : m_word[i][7:0];
   endfunction

   // Next requester to be served: first missing one, cyclically from m_ptr
   function automatic int exp_grant();
      for (int k = 0; k < 3; k++) begin
         int j;
         j = (m_ptr + k) % 3;
         if (req_cs(j) && !exp_ok(j)) return j;
      end
      return -1;
   endfunction

   function automatic logic dut_ok(int i);
      return (i == 0) ? main_ok : (i == 1) ? snd_ok : pcm_ok;
   endfunction

   function automatic logic [7:0] dut_data(int i);
      return (i == 0) ? main_data : (i == 1) ? snd_data : pcm_data;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_word[i]  = '0;
      end
      m_ptr = 0;
   endtask

   task automatic model_fill(input int g, input logic [15:0] w);
      m_valid[g] = 1'b1;
      m_tag[g]   = req_word(g);
      m_word[g]  = w;
      m_ptr      = (g + 1) % 3;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      downloading = 1'b0;
      main_cs     = 1'b0;
      snd_cs      = 1'b0;
      pcm_cs      = 1'b0;
      main_addr   = '0;
      snd_addr    = '0;
      pcm_addr    = '0;
      ba_ack      = 1'b0;
      ba_rdy      = 1'b0;
      data_read   = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      model_reset();
   endtask

   // Bank responder: waits for ba_rd, then answers with ack and rdy after the
   // given delays (or both together in the first request cycle).
   task automatic serve(input int ack_wait, input int rdy_wait, input bit same,
                        input logic [15:0] word, output logic [21:0] addr, output bit got);
      int n;
      n    = 0;
      got  = 1'b0;
      addr = '0;
      while (!ba_rd && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (ba_rd !== 1'b1) begin
         failures++;
         $display("FAIL serve_timeout: ba_rd=%b, required 1 within 20 cycles", ba_rd);
         return;
      end
      got  = 1'b1;
      addr = ba_addr;
      if (same) begin
         ba_ack    = 1'b1;
         ba_rdy    = 1'b1;
         data_read = word;
         tick();
         ba_ack    = 1'b0;
         ba_rdy    = 1'b0;
         data_read = 16'($urandom);
      end else begin
         repeat (ack_wait) tick();
         checks++;
         if (ba_rd !== 1'b1 || ba_addr !== addr) begin
            failures++;
            $display("FAIL serve_hold: ba_rd=%b ba_addr=%h, required 1 / %h", ba_rd, ba_addr, addr);
         end
         ba_ack = 1'b1;
         tick();
         ba_ack = 1'b0;
         repeat (rdy_wait) tick();
         ba_rdy    = 1'b1;
         data_read = word;
         tick();
         ba_rdy    = 1'b0;
         data_read = 16'($urandom);
      end
   endtask

   task automatic test_reset();
      do_reset();
      rst_n   = 1'b0;
      main_cs = 1'b1;
      snd_cs  = 1'b1;
      pcm_cs  = 1'b1;
      main_addr = 16'h0013;
      snd_addr  = 15'h0021;
      pcm_addr  = 17'h00031;
      tick();
      checks++;
      if (ba_rd !== 1'b0 || ba_addr !== 22'h0) begin
         failures++;
         $display("FAIL reset_bank: ba_rd=%b ba_addr=%h, required 0 / 000000", ba_rd, ba_addr);
      end
      checks++;
      if ({main_ok, snd_ok, pcm_ok} !== 3'b000) begin
         failures++;
         $display("FAIL reset_ok: ok=%b, required 000", {main_ok, snd_ok, pcm_ok});
      end
      checks++;
      if ({main_data, snd_data, pcm_data} !== 24'h0) begin
         failures++;
         $display("FAIL reset_data: data=%h, required 000000", {main_data, snd_data, pcm_data});
      end
      main_cs = 1'b0;
      snd_cs  = 1'b0;
      pcm_cs  = 1'b0;
      rst_n   = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic test_main_miss_hit();
      do_reset();
      main_cs   = 1'b1;
      main_addr = 16'h0004;
      #1;
      checks++;
      if (main_ok !== 1'b0 || ba_rd !== 1'b0) begin
         failures++;
         $display("FAIL mm_miss: main_ok=%b ba_rd=%b, required 0 / 0", main_ok, ba_rd);
      end
      tick();
      checks++;
      if (ba_rd !== 1'b1 || ba_addr !== 22'h2) begin
         failures++;
         $display("FAIL mm_req: ba_rd=%b ba_addr=%h, required 1 / 000002", ba_rd, ba_addr);
      end
      repeat (2) tick();
      checks++;
      if (ba_rd !== 1'b1 || ba_addr !== 22'h2) begin
         failures++;
         $display("FAIL mm_hold: ba_rd=%b ba_addr=%h, required 1 / 000002", ba_rd, ba_addr);
      end
      ba_ack = 1'b1;
      tick();
      ba_ack = 1'b0;
      checks++;
      if (ba_rd !== 1'b0) begin
         failures++;
         $display("FAIL mm_ack: ba_rd=%b, required 0", ba_rd);
      end
      repeat (2) tick();
      checks++;
      if (main_ok !== 1'b0) begin
         failures++;
         $display("FAIL mm_early_ok: main_ok=%b, required 0 before ba_rdy", main_ok);
      end
      ba_rdy    = 1'b1;
      data_read = 16'hBEEF;
      tick();
      ba_rdy    = 1'b0;
      data_read = 16'h0000;
      model_fill(0, 16'hBEEF);
      checks++;
      if (main_ok !== 1'b1 || main_data !== 8'hEF) begin
         failures++;
         $display("FAIL mm_fill: main_ok=%b main_data=%h, required 1 / ef", main_ok, main_data);
      end
      main_addr = 16'h0005;
      #1;
      checks++;
      if (main_ok !== 1'b1 || main_data !== 8'hBE || ba_rd !== 1'b0) begin
         failures++;
         $display("FAIL mm_hit: main_ok=%b main_data=%h ba_rd=%b, required 1 / be / 0",
                  main_ok, main_data, ba_rd);
      end
      tick();
      checks++;
      if (ba_rd !== 1'b0) begin
         failures++;
         $display("FAIL mm_hit_norq: ba_rd=%b, required 0", ba_rd);
      end
      main_cs = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [21:0] want [3];
      logic [21:0] a;
      bit          got;
      logic [15:0] w;
      do_reset();
      want[0] = 22'h00020;
      want[1] = 22'h08021;
      want[2] = 22'h1BFFF;
      main_cs   = 1'b1;
      snd_cs    = 1'b1;
      pcm_cs    = 1'b1;
      main_addr = 16'h0040;
      snd_addr  = 15'h0042;
      pcm_addr  = 17'h1FFFF;
      for (int k = 0; k < 3; k++) begin
         w = 16'($urandom);
         serve(1, 1, 1'b0, w, a, got);
         if (!got) return;
         checks++;
         if (a !== want[k] || a !== exp_ba(k)) begin
            failures++;
            $display("FAIL rr_order%0d: ba_addr=%h, required %h", k, a, want[k]);
         end
         model_fill(k, w);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (dut_ok(i) !== 1'b1 || dut_data(i) !== exp_data(i)) begin
            failures++;
            $display("FAIL rr_hit%0d: ok=%b data=%h, required 1 / %h", i, dut_ok(i), dut_data(i),
                     exp_data(i));
         end
      end
      main_cs = 1'b0;
      snd_cs  = 1'b0;
      pcm_cs  = 1'b0;
   endtask

   task automatic test_fairness();
      logic [21:0] a;
      bit          got;
      do_reset();
      main_cs   = 1'b1;
      main_addr = 16'h0010;
      snd_cs    = 1'b1;
      snd_addr  = 15'h0020;
      serve(0, 0, 1'b0, 16'h1111, a, got);
      if (!got) return;
      checks++;
      if (a !== 22'h00008) begin
         failures++;
         $display("FAIL fair_first: ba_addr=%h, required 000008", a);
      end
      model_fill(0, 16'h1111);
      main_addr = 16'h0030;
      serve(0, 0, 1'b0, 16'h2222, a, got);
      if (!got) return;
      checks++;
      if (a !== 22'h08010) begin
         failures++;
         $display("FAIL fair_snd: ba_addr=%h, required 008010", a);
      end
      model_fill(1, 16'h2222);
      serve(0, 0, 1'b0, 16'h3333, a, got);
      if (!got) return;
      checks++;
      if (a !== 22'h00018) begin
         failures++;
         $display("FAIL fair_third: ba_addr=%h, required 000018", a);
      end
      model_fill(0, 16'h3333);
      main_cs = 1'b0;
      snd_cs  = 1'b0;
   endtask

   task automatic test_same_cycle();
      logic [21:0] a;
      bit          got;
      main_cs   = 1'b1;
      main_addr = 16'h0201;
      snd_cs    = 1'b0;
      pcm_cs    = 1'b0;
      serve(0, 0, 1'b1, 16'hA55A, a, got);
      if (!got) return;
      checks++;
      if (a !== 22'h00100) begin
         failures++;
         $display("FAIL same_addr: ba_addr=%h, required 000100", a);
      end
      model_fill(0, 16'hA55A);
      checks++;
      if (main_ok !== 1'b1 || main_data !== 8'hA5) begin
         failures++;
         $display("FAIL same_fill: main_ok=%b main_data=%h, required 1 / a5", main_ok, main_data);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (ba_rd !== 1'b0 || main_ok !== 1'b1) begin
            failures++;
            $display("FAIL same_single%0d: ba_rd=%b main_ok=%b, required 0 / 1", k, ba_rd, main_ok);
         end
      end
      main_cs = 1'b0;
   endtask

   task automatic test_download_abort();
      logic [21:0] a;
      bit          got;
      int          n;
      do_reset();
      snd_cs   = 1'b1;
      snd_addr = 15'h0002;
      serve(0, 0, 1'b0, 16'h5678, a, got);
      if (!got) return;
      model_fill(1, 16'h5678);
      main_cs   = 1'b1;
      main_addr = 16'h0100;
      n = 0;
      while (!ba_rd && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (ba_rd !== 1'b1 || ba_addr !== 22'h00080 || snd_ok !== 1'b1) begin
         failures++;
         $display("FAIL dl_req: ba_rd=%b ba_addr=%h snd_ok=%b, required 1 / 000080 / 1",
                  ba_rd, ba_addr, snd_ok);
      end
      ba_ack = 1'b1;
      tick();
      ba_ack      = 1'b0;
      downloading = 1'b1;
      tick();
      checks++;
      if (ba_rd !== 1'b0 || {main_ok, snd_ok, pcm_ok} !== 3'b000) begin
         failures++;
         $display("FAIL dl_abort: ba_rd=%b ok=%b, required 0 / 000", ba_rd, {main_ok, snd_ok, pcm_ok});
      end
      ba_rdy    = 1'b1;
      data_read = 16'hDEAD;
      tick();
      ba_rdy = 1'b0;
      checks++;
      if (main_ok !== 1'b0 || ba_rd !== 1'b0) begin
         failures++;
         $display("FAIL dl_nofill: main_ok=%b ba_rd=%b, required 0 / 0", main_ok, ba_rd);
      end
      for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
      snd_cs      = 1'b0;
      downloading = 1'b0;
      tick();
      checks++;
      if (ba_rd !== 1'b1 || ba_addr !== 22'h00080) begin
         failures++;
         $display("FAIL dl_refetch: ba_rd=%b ba_addr=%h, required 1 / 000080", ba_rd, ba_addr);
      end
      serve(0, 1, 1'b0, 16'h9ABC, a, got);
      if (!got) return;
      model_fill(0, 16'h9ABC);
      checks++;
      if (main_ok !== 1'b1 || main_data !== 8'hBC) begin
         failures++;
         $display("FAIL dl_after: main_ok=%b main_data=%h, required 1 / bc", main_ok, main_data);
      end
      main_cs = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [21:0] a;
      bit          got;
      int          n;
      do_reset();
      snd_cs   = 1'b1;
      snd_addr = 15'h0002;
      serve(0, 0, 1'b0, 16'h4321, a, got);
      if (!got) return;
      model_fill(1, 16'h4321);
      main_cs   = 1'b1;
      main_addr = 16'h0006;
      n = 0;
      while (!ba_rd && n < 20) begin
         tick();
         n++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ba_rd !== 1'b0 || {main_ok, snd_ok, pcm_ok} !== 3'b000 || snd_data !== 8'h00) begin
         failures++;
         $display("FAIL ar_now: ba_rd=%b ok=%b snd_data=%h, required 0 / 000 / 00",
                  ba_rd, {main_ok, snd_ok, pcm_ok}, snd_data);
      end
      main_cs = 1'b0;
      snd_cs  = 1'b0;
      #1;
      rst_n = 1'b1;
      model_reset();
      tick();
      ba_rdy    = 1'b1;
      data_read = 16'h7777;
      tick();
      ba_rdy    = 1'b0;
      main_cs   = 1'b1;
      #1;
      checks++;
      if (main_ok !== 1'b0 || ba_rd !== 1'b0 || main_data !== 8'h00) begin
         failures++;
         $display("FAIL ar_late_rdy: main_ok=%b ba_rd=%b main_data=%h, required 0 / 0 / 00",
                  main_ok, ba_rd, main_data);
      end
      serve(0, 0, 1'b0, 16'h0F0F, a, got);
      if (!got) return;
      checks++;
      if (a !== 22'h00003) begin
         failures++;
         $display("FAIL ar_refetch: ba_addr=%h, required 000003", a);
      end
      model_fill(0, 16'h0F0F);
      main_cs = 1'b0;
   endtask

   task automatic test_random();
      logic [21:0] a;
      bit          got;
      int          g;
      logic [15:0] w;
      for (int it = 0; it < 60; it++) begin
         main_cs   = 1'($urandom_range(0, 1));
         snd_cs    = 1'($urandom_range(0, 1));
         pcm_cs    = 1'($urandom_range(0, 1));
         main_addr = 16'($urandom_range(0, 15));
         snd_addr  = 15'($urandom_range(0, 15));
         pcm_addr  = 17'($urandom_range(0, 15)) | (($urandom_range(0, 1) != 0) ? 17'h1FFF0 : 17'h0);
         #1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_ok(i) !== exp_ok(i) || dut_data(i) !== exp_data(i)) begin
               failures++;
               $display("FAIL rnd_pre it%0d req%0d: ok=%b data=%h, required %b / %h",
                        it, i, dut_ok(i), dut_data(i), exp_ok(i), exp_data(i));
            end
         end
         for (int t = 0; t < 3; t++) begin
            g = exp_grant();
            if (g < 0) break;
            w = 16'($urandom);
            serve($urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 3) == 0), w, a, got);
            if (!got) break;
            checks++;
            if (a !== exp_ba(g)) begin
               failures++;
               $display("FAIL rnd_grant it%0d: ba_addr=%h, required %h (req%0d)", it, a, exp_ba(g), g);
            end
            model_fill(g, w);
            for (int i = 0; i < 3; i++) begin
               checks++;
               if (dut_ok(i) !== exp_ok(i) || dut_data(i) !== exp_data(i)) begin
                  failures++;
                  $display("FAIL rnd_post it%0d req%0d: ok=%b data=%h, required %b / %h",
                           it, i, dut_ok(i), dut_data(i), exp_ok(i), exp_data(i));
               end
            end
         end
         tick();
         checks++;
         if (ba_rd !== 1'b0) begin
            failures++;
            $display("FAIL rnd_idle it%0d: ba_rd=%b, required 0", it, ba_rd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_main_miss_hit();
      test_round_robin();
      test_fairness();
      test_same_cycle();
      test_download_abort();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jtkunio_rom_arb.md
# jtkunio_rom_arb

Read-only SDRAM bank arbiter that shares one bank port (ba_rd/ba_ack/ba_rdy) between three 8-bit ROM requesters: main CPU, sound CPU and PCM sample fetch. Each requester gets a one-word (16-bit) cache, so sequential byte reads hit without a new SDRAM access. Misses are serialised by a round-robin grant. The block sits between the CPU/sound modules and the SDRAM bank port, below the game top level.

## Interface
Parameters:
- MAIN_AW, 16, main byte-address width
- SND_AW, 15, sound byte-address width
- PCM_AW, 17, PCM byte-address width
- SND_OFFSET, 22'h08000, word offset of sound ROM in bank
- PCM_OFFSET, 22'h0C000, word offset of PCM ROM in bank

Ports:
- clk  in  1  system clock; the single clock for all logic
- rst_n  in  1  reset; asynchronous assert, active-low
- downloading  in  1  ROM download in progress
- main_cs / snd_cs / pcm_cs  in  1 each  request strobe, level
- main_addr / snd_addr / pcm_addr  in  MAIN_AW / SND_AW / PCM_AW  byte address
- main_data / snd_data / pcm_data  out  8 each  read byte
- main_ok / snd_ok / pcm_ok  out  1 each  data valid for current cs/addr
- ba_addr  out  22  word address to SDRAM bank
- ba_rd  out  1  read request
- ba_ack  in  1  request accepted
- ba_rdy  in  1  data_read valid
- data_read  in  16  SDRAM read word

## Operation
- Per requester i: tag_i (address bits above bit 0), word_i[15:0], valid_i.
- Hit: cs_i & valid_i & (addr_i[AW-1:1] == tag_i). ok_i and data_i are combinational from the registers. data_i = addr_i[0] ? word_i[15:8] : word_i[7:0].
- Miss: cs_i & ~hit_i sets a pending request.
- FSM states:
  - IDLE: if any request is pending and downloading=0, grant by round-robin. Order main→snd→pcm, starting after the last granted requester. Latch gnt and ba_addr = offset_i + addr_i[AW-1:1], zero-extended to 22 bits; main offset is 0. Set ba_rd=1. Go to WAIT_ACK.
  - WAIT_ACK: hold ba_rd and ba_addr stable. On ba_ack, clear ba_rd and go to WAIT_RDY.
  - WAIT_RDY: on ba_rdy, write word_gnt = data_read, tag_gnt = latched address, valid_gnt = 1. Update the round-robin pointer and go to IDLE.
- A requester that drops cs or changes address mid-transaction still has its transaction completed and its cache filled. Its ok follows the tag compare against its current address.
- ba_ack and ba_rdy arriving in the same cycle in WAIT_ACK: treat as ack followed by rdy; the fill happens that cycle.
- downloading=1:
  - Clears all valid bits every cycle.
  - Forces the FSM to IDLE with ba_rd=0, abandoning any transaction.
  - Blocks new grants.
- Address arithmetic wraps modulo 2^22; there is no overflow check.

## Timing
- Reset values: ba_rd=0, ba_addr=0, all valid=0, all word/tag=0, pointer=main. Consequently all ok=0 and all data=8'h00.
- Hit: ok asserts in the same cycle as cs or address presentation (0 latency).
- Miss: the grant registers at the first edge with the miss pending, so ba_rd is high the next cycle. The fill registers on the ba_rdy edge, and ok is high the cycle after. Best case with ack and rdy one cycle each: ok 3 cycles after the miss.
- At most one outstanding transaction; ba_rd is never reasserted before ba_rdy.
- Worst-case wait for a requester is two other full transactions.
- Asynchronous reset mid-transaction: outputs take their reset values immediately. Late ba_ack or ba_rdy seen in IDLE are ignored.

## Structure
- Package jtkunio_rom_pkg holds:
  - state enum IDLE/WAIT_ACK/WAIT_RDY
  - requester index constants MAIN=0, SND=1, PCM=2
- The per-requester cache (tag, word, valid, hit compare, byte mux) is a natural sub-module, jtkunio_rom_slot, instantiated three times with the AW parameter. The FSM and round-robin logic stay at top level.

## Test plan
- Main miss then hit: main_cs=1, addr=16'h0004, ack and rdy each after 2 cycles, data_read=16'hBEEF. Required: ba_addr=22'h2, main_data=8'hEF. Then addr=16'h0005 gives ok on the same cycle with data 8'hBE and no ba_rd.
- Round-robin: all three miss simultaneously from reset. Required grant order main, snd, pcm. snd ba_addr = 22'h08000 + (snd_addr>>1); pcm ba_addr = 22'h0C000 + (pcm_addr>>1).
- Fairness: main misses continuously while snd is pending. Required: snd is granted no later than the second transaction.
- Same-cycle ack and rdy: ba_ack and ba_rdy both asserted in the first WAIT_ACK cycle. Required: single fill, and ok the next cycle.
- Download abort: assert downloading during WAIT_RDY. Required: ba_rd=0, FSM in IDLE, all ok=0. After deassertion, the same address is re-fetched.
- Async reset: drop rst_n mid-WAIT_ACK. Required: ba_rd=0 and all ok=0 in the same cycle; a later ba_rdy pulse causes no fill.
